// File: rtl/joy_cursor_ctrl.sv
// Joystick-to-cursor controller: classifies joystick samples and steps a windowed (x,y) cursor on tick rising edges.
// Define CURSOR_WRAP_EN to wrap out-of-window results to the opposite bound instead of saturating.

module joy_cursor_axis #(
    parameter int AW          = 10,
    parameter int PW          = 10,
    parameter int P_MIN       = 0,
    parameter int P_MAX       = 1023,
    parameter int P_INIT      = 0,
    parameter int TH_LO_FAR   = 150,
    parameter int TH_LO_NEAR  = 400,
    parameter int TH_HI_NEAR  = 600,
    parameter int TH_HI_FAR   = 850,
    parameter int STEP_SLOW   = 10,
    parameter int STEP_FAST   = 20,
    parameter int STEP_TURBO  = 40,
    parameter int ACCEL_TICKS = 4,
    parameter int INV         = 0
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          step,
    input  logic          en,
    input  logic [AW-1:0] joy,
    output logic [PW-1:0] pos,
    output logic          changed,
    output logic [1:0]    dbg_state
);
    typedef enum logic [1:0] {REST = 2'd0, SLOW = 2'd1, FAST = 2'd2, TURBO = 2'd3} state_e;

    localparam int CW = $clog2(ACCEL_TICKS + 1);
    localparam logic [AW-1:0] TH_LF = AW'(TH_LO_FAR);
    localparam logic [AW-1:0] TH_LN = AW'(TH_LO_NEAR);
    localparam logic [AW-1:0] TH_HN = AW'(TH_HI_NEAR);
    localparam logic [AW-1:0] TH_HF = AW'(TH_HI_FAR);
    localparam logic [CW-1:0] ACC_MAX = CW'(ACCEL_TICKS);
    localparam logic signed [PW+1:0] MIN_S   = (PW+2)'(P_MIN);
    localparam logic signed [PW+1:0] MAX_S   = (PW+2)'(P_MAX);
    localparam logic signed [PW+1:0] SLOW_S  = (PW+2)'(STEP_SLOW);
    localparam logic signed [PW+1:0] FAST_S  = (PW+2)'(STEP_FAST);
    localparam logic signed [PW+1:0] TURBO_S = (PW+2)'(STEP_TURBO);
    localparam logic INV_B = (INV != 0);

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 dir_neg_q, dir_neg_d;
    logic [PW-1:0]        pos_q, pos_d;
    logic                 is_far, is_near, is_neg, same_run;
    logic signed [PW+1:0] amt, pos_ext, sum;

    always_comb begin
        is_far   = (joy < TH_LF) || (joy > TH_HF);
        is_near  = !is_far && ((joy < TH_LN) || (joy > TH_HN));
        is_neg   = (joy < TH_LN);
        // A run continues only if the previous step was FAR in the same direction.
        same_run = ((state_q == FAST) || (state_q == TURBO)) && (dir_neg_q == is_neg);
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dir_neg_d = dir_neg_q;
        pos_d     = pos_q;
        amt       = '0;
        pos_ext   = $signed({2'b00, pos_q});
        sum       = pos_ext;
        if (!en) begin
            state_d = REST;
            cnt_d   = '0;
        end else if (step) begin
            if (is_far) begin
                dir_neg_d = is_neg;
                if (same_run) begin
                    cnt_d = (cnt_q >= ACC_MAX) ? ACC_MAX : cnt_q + CW'(1);
                    if (cnt_q >= ACC_MAX) begin
                        state_d = TURBO;
                        amt     = TURBO_S;
                    end else begin
                        state_d = FAST;
                        amt     = FAST_S;
                    end
                end else begin
                    cnt_d   = CW'(1);
                    state_d = FAST;
                    amt     = FAST_S;
                end
            end else if (is_near) begin
                state_d = SLOW;
                cnt_d   = '0;
                amt     = SLOW_S;
            end else begin
                state_d = REST;
                cnt_d   = '0;
            end
            sum = (is_neg ^ INV_B) ? (pos_ext - amt) : (pos_ext + amt);
`ifdef CURSOR_WRAP_EN
            if (sum > MAX_S)      pos_d = PW'(P_MIN);
            else if (sum < MIN_S) pos_d = PW'(P_MAX);
            else                  pos_d = sum[PW-1:0];
`else
            if (sum > MAX_S)      pos_d = PW'(P_MAX);
            else if (sum < MIN_S) pos_d = PW'(P_MIN);
            else                  pos_d = sum[PW-1:0];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q   <= REST;
            cnt_q     <= '0;
            dir_neg_q <= 1'b0;
            pos_q     <= PW'(P_INIT);
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dir_neg_q <= dir_neg_d;
            pos_q     <= pos_d;
        end
    end

    assign pos       = pos_q;
    assign changed   = step && (pos_d != pos_q);
    assign dbg_state = state_q;
endmodule

module joy_cursor_ctrl #(
    parameter int AW          = 10,
    parameter int PW          = 10,
    parameter int X_MIN       = 566,
    parameter int X_MAX       = 689,
    parameter int Y_MIN       = 116,
    parameter int Y_MAX       = 426,
    parameter int X_INIT      = 627,
    parameter int Y_INIT      = 271,
    parameter int TH_LO_FAR   = 150,
    parameter int TH_LO_NEAR  = 400,
    parameter int TH_HI_NEAR  = 600,
    parameter int TH_HI_FAR   = 850,
    parameter int STEP_SLOW   = 10,
    parameter int STEP_FAST   = 20,
    parameter int STEP_TURBO  = 40,
    parameter int ACCEL_TICKS = 4,
    parameter int INV_X       = 1,
    parameter int INV_Y       = 0
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          tick,
    input  logic          en,
    input  logic [AW-1:0] joy_x,
    input  logic [AW-1:0] joy_y,
    output logic [PW-1:0] dot_x,
    output logic [PW-1:0] dot_y,
    output logic          moving,
    output logic [3:0]    at_edge,
    output logic [1:0]    dbg_state_x,
    output logic [1:0]    dbg_state_y
);
    logic tick_q, tick_d, moving_q, moving_d;
    logic step, chg_x, chg_y;

    always_comb begin
        step     = en & tick & ~tick_q;
        tick_d   = tick;
        moving_d = step ? (chg_x | chg_y) : moving_q;
    end

    // tick_q resets high so a tick held through reset needs a fresh low->high edge.
    always_ff @(posedge clk) begin
        if (clr) begin
            tick_q   <= 1'b1;
            moving_q <= 1'b0;
        end else begin
            tick_q   <= tick_d;
            moving_q <= moving_d;
        end
    end

    joy_cursor_axis #(
        .AW(AW), .PW(PW), .P_MIN(X_MIN), .P_MAX(X_MAX), .P_INIT(X_INIT),
        .TH_LO_FAR(TH_LO_FAR), .TH_LO_NEAR(TH_LO_NEAR), .TH_HI_NEAR(TH_HI_NEAR), .TH_HI_FAR(TH_HI_FAR),
        .STEP_SLOW(STEP_SLOW), .STEP_FAST(STEP_FAST), .STEP_TURBO(STEP_TURBO),
        .ACCEL_TICKS(ACCEL_TICKS), .INV(INV_X)
    ) u_axis_x (
        .clk(clk), .clr(clr), .step(step), .en(en), .joy(joy_x),
        .pos(dot_x), .changed(chg_x), .dbg_state(dbg_state_x)
    );

    joy_cursor_axis #(
        .AW(AW), .PW(PW), .P_MIN(Y_MIN), .P_MAX(Y_MAX), .P_INIT(Y_INIT),
        .TH_LO_FAR(TH_LO_FAR), .TH_LO_NEAR(TH_LO_NEAR), .TH_HI_NEAR(TH_HI_NEAR), .TH_HI_FAR(TH_HI_FAR),
        .STEP_SLOW(STEP_SLOW), .STEP_FAST(STEP_FAST), .STEP_TURBO(STEP_TURBO),
        .ACCEL_TICKS(ACCEL_TICKS), .INV(INV_Y)
    ) u_axis_y (
        .clk(clk), .clr(clr), .step(step), .en(en), .joy(joy_y),
        .pos(dot_y), .changed(chg_y), .dbg_state(dbg_state_y)
    );

    assign moving  = moving_q;
    assign at_edge = {dot_y == PW'(Y_MAX), dot_y == PW'(Y_MIN), dot_x == PW'(X_MAX), dot_x == PW'(X_MIN)};
endmodule

// File: tb/tb_joy_cursor_ctrl.sv
// Bench for joy_cursor_ctrl: directed vector table, hand-written corner sequences and random ticks
// checked against an arithmetic model of the cursor rules.

module tb_joy_cursor_ctrl;
    localparam int X_MIN = 566, X_MAX = 689, Y_MIN = 116, Y_MAX = 426;
    localparam int X_INIT = 627, Y_INIT = 271, ACCEL = 4;
`ifdef CURSOR_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       tick = 1'b0;
    logic       en = 1'b1;
    logic [9:0] joy_x = 10'd512;
    logic [9:0] joy_y = 10'd512;
    logic [9:0] dot_x, dot_y;
    logic       moving;
    logic [3:0] at_edge;
    logic [1:0] dbg_state_x, dbg_state_y;

    int checks = 0;
    int failures = 0;

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    joy_cursor_ctrl dut (
        .clk(clk), .clr(clr), .tick(tick), .en(en), .joy_x(joy_x), .joy_y(joy_y),
        .dot_x(dot_x), .dot_y(dot_y), .moving(moving), .at_edge(at_edge),
        .dbg_state_x(dbg_state_x), .dbg_state_y(dbg_state_y)
    );

    // reference model: positions, run lengths of same-direction FAR ticks, last FAR class
    int m_x, m_y, m_rx, m_ry, m_lx, m_ly, m_mov;

    function automatic int classify(input int s);
        if (s < 150) return -2;
        if (s < 400) return -1;
        if (s > 850) return 2;
        if (s > 600) return 1;
        return 0;
    endfunction

    function automatic int edge_of(input int x, input int y);
        return ((y == Y_MAX) ? 8 : 0) + ((y == Y_MIN) ? 4 : 0) + ((x == X_MAX) ? 2 : 0) + ((x == X_MIN) ? 1 : 0);
    endfunction

    task automatic model_reset();
        m_x = X_INIT; m_y = Y_INIT;
        m_rx = 0; m_ry = 0; m_lx = 0; m_ly = 0; m_mov = 0;
    endtask

    task automatic model_axis(input int c, input int lo, input int hi, input bit inv,
                              inout int pos, inout int run, inout int last);
        int amt, mag, nxt;
        mag = (c < 0) ? -c : c;
        if (mag == 2) begin
            if (run > 0 && last == c) begin
                amt = (run >= ACCEL) ? 40 : 20;
                if (run < ACCEL) run++;
            end else begin
                amt = 20;
                run = 1;
            end
            last = c;
        end else begin
            amt = (mag == 1) ? 10 : 0;
            run = 0;
        end
        nxt = ((c < 0) != inv) ? pos - amt : pos + amt;
        if (nxt > hi)      pos = WRAP ? lo : hi;
        else if (nxt < lo) pos = WRAP ? hi : lo;
        else               pos = nxt;
    endtask

    task automatic model_step(input int jx, input int jy, input bit e);
        int ox, oy;
        if (!e) begin
            m_rx = 0; m_ry = 0;
            return;
        end
        ox = m_x; oy = m_y;
        model_axis(classify(jx), X_MIN, X_MAX, 1'b1, m_x, m_rx, m_lx);
        model_axis(classify(jy), Y_MIN, Y_MAX, 1'b0, m_y, m_ry, m_ly);
        m_mov = ((m_x != ox) || (m_y != oy)) ? 1 : 0;
    endtask

    // driver tasks
    task automatic do_reset();
        @(negedge clk);
        tick = 1'b0; clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        model_reset();
    endtask

    task automatic drive_tick(input int jx, input int jy, input bit e);
        @(negedge clk);
        joy_x = 10'(jx); joy_y = 10'(jy); en = e; tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        model_step(jx, jy, e);
    endtask

    // scoreboard
    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, "_x"}, dot_x, m_x);
        check({tag, "_y"}, dot_y, m_y);
        check({tag, "_mov"}, moving, m_mov);
        check({tag, "_edge"}, at_edge, edge_of(m_x, m_y));
    endtask

    function automatic int rand_joy();
        int b[8] = '{149, 150, 399, 400, 600, 601, 850, 851};
        case ($urandom_range(0, 5))
            0: return $urandom_range(0, 149);
            1: return $urandom_range(150, 399);
            2: return $urandom_range(400, 600);
            3: return $urandom_range(601, 850);
            4: return $urandom_range(851, 1023);
            default: return b[$urandom_range(0, 7)];
        endcase
    endfunction

    typedef struct {
        int jx; int jy; int e; int ex; int ey; int em;
    } vec_t;
    vec_t vt[14];

    initial begin
        int jx, jy;
        bit e;

        vt[0]  = '{100, 512, 1, 647, 271, 1};
        vt[1]  = '{512, 300, 1, 647, 261, 1};
        vt[2]  = '{512, 700, 1, 647, 271, 1};
        vt[3]  = '{512, 512, 1, 647, 271, 0};
        vt[4]  = '{100, 900, 1, 667, 291, 1};
        vt[5]  = '{100, 900, 1, 687, 311, 1};
        vt[6]  = '{100, 900, 1, 689, 331, 1};
        vt[7]  = '{100, 900, 1, 689, 351, 1};
        vt[8]  = '{100, 900, 1, 689, 391, 1};
        vt[9]  = '{100, 512, 1, 689, 391, 0};
        vt[10] = '{512, 900, 1, 689, 411, 1};
        vt[11] = '{512, 900, 1, 689, 426, 1};
        vt[12] = '{512, 900, 1, 689, 426, 0};
        vt[13] = '{900, 100, 1, 669, 406, 1};

        do_reset();
        check("reset_x", dot_x, X_INIT);
        check("reset_y", dot_y, Y_INIT);
        check("reset_mov", moving, 0);
        check("reset_edge", at_edge, 0);

`ifndef CURSOR_WRAP_EN
        for (int i = 0; i < 14; i++) begin
            drive_tick(vt[i].jx, vt[i].jy, vt[i].e[0]);
            check($sformatf("vec%0d_x", i), dot_x, vt[i].ex);
            check($sformatf("vec%0d_y", i), dot_y, vt[i].ey);
            check($sformatf("vec%0d_mov", i), moving, vt[i].em);
            check($sformatf("vec%0d_edge", i), at_edge, edge_of(vt[i].ex, vt[i].ey));
        end
`else
        for (int i = 0; i < 3; i++) drive_tick(100, 512, 1'b1);
        check("wrap_pre", dot_x, 687);
        drive_tick(100, 512, 1'b1);
        check("wrap_hi", dot_x, X_MIN);
        drive_tick(900, 512, 1'b1);
        check("wrap_lo", dot_x, X_MAX);
`endif

        // tick held high through clr mid-motion: no step until a fresh rising edge
        do_reset();
        drive_tick(100, 900, 1'b1);
        drive_tick(100, 900, 1'b1);
        check_model("pre_clr");
        @(negedge clk);
        tick = 1'b1; clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("hold_hi_x", dot_x, X_INIT);
        check("hold_hi_y", dot_y, Y_INIT);
        check("hold_hi_mov", moving, 0);
        @(negedge clk);
        tick = 1'b0;
        drive_tick(100, 900, 1'b1);
        check("after_hold_x", dot_x, 647);
        check("after_hold_y", dot_y, 291);

        // clr coinciding with a step event
        @(negedge clk);
        joy_x = 10'd100; joy_y = 10'd900; tick = 1'b1; clr = 1'b1;
        @(negedge clk);
        clr = 1'b0; tick = 1'b0;
        model_reset();
        check_model("clr_wins");

        // en=0 freezes the cursor and breaks the acceleration run
        for (int i = 0; i < 4; i++) drive_tick(512, 900, 1'b1);
        check("run_y", dot_y, 351);
        drive_tick(512, 900, 1'b0);
        check("en0_hold", dot_y, 351);
        check_model("en0");
        drive_tick(512, 900, 1'b1);
        check("en0_clear", dot_y, 371);

        // randomized ticks against the model
        do_reset();
        jx = 512; jy = 512;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 39) == 0) do_reset();
            if ($urandom_range(0, 1) == 0) jx = rand_joy();
            if ($urandom_range(0, 1) == 0) jy = rand_joy();
            e = ($urandom_range(0, 7) != 0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            drive_tick(jx, jy, e);
            check_model($sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
